// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module : draw_pkg
// Brief  : Shared drawing constants, colours and arbiter state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [C_W-1:0] BLACK = 3'b000;
    localparam logic [C_W-1:0] WHITE = 3'b111;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage : draw_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector; first set request from i_ptr.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int IW = $clog2(N);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int w_i;
            w_i = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_i]) begin
                w_found    = 1'b1;
                o_gnt[w_i] = 1'b1;
                o_idx      = IW'(w_i);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module : plot_arbiter
// Brief  : Round-robin framebuffer write-port arbiter with locked bursts.
//          Optional screen clipping when PLOT_ARB_CLIP_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module plot_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int X_W       = draw_pkg::X_W,
    parameter int Y_W       = draw_pkg::Y_W,
    parameter int C_W       = draw_pkg::C_W,
    parameter int MAX_BURST = 16,
    parameter int X_MAX     = draw_pkg::SCREEN_W,
    parameter int Y_MAX     = draw_pkg::SCREEN_H
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ*C_W-1:0]     req_color,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [X_W-1:0]             x,
    output logic [Y_W-1:0]             y,
    output logic [C_W-1:0]             color_draw,
    output logic                       plot,
    output logic                       locked,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    import draw_pkg::*;

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [X_W:0] c_X_LIM = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] c_Y_LIM = (Y_W+1)'(Y_MAX);

    arb_state_t        r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_owner;
    logic [BW-1:0]     r_burst;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [C_W-1:0]    r_color;
    logic              r_plot;

    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [PW-1:0]      w_rr_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PW-1:0]      w_sel;
    logic [PW-1:0]      w_ptr_next;
    logic [X_W-1:0]     w_sel_x;
    logic [Y_W-1:0]     w_sel_y;
    logic [C_W-1:0]     w_sel_c;
    logic               w_any;
    logic               w_oob;
    logic               w_clip;
    logic               w_last;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx)
    );

    // In LOCKED only the owner may be granted; everyone else waits.
    always_comb begin
        w_gnt = '0;
        w_sel = w_rr_idx;
        if (!reset) begin
            if (r_state == ARB) begin
                w_gnt = w_rr_gnt;
            end else begin
                w_gnt[r_owner] = req[r_owner];
                w_sel          = r_owner;
            end
        end
    end

    assign w_any      = |w_gnt;
    assign w_sel_x    = req_x[int'(w_sel)*X_W +: X_W];
    assign w_sel_y    = req_y[int'(w_sel)*Y_W +: Y_W];
    assign w_sel_c    = req_color[int'(w_sel)*C_W +: C_W];
    assign w_oob      = ({1'b0, w_sel_x} >= c_X_LIM) || ({1'b0, w_sel_y} >= c_Y_LIM);
    assign w_last     = (r_burst == BW'(MAX_BURST - 1));
    assign w_ptr_next = (w_rr_idx == PW'(NUM_REQ - 1)) ? '0 : w_rr_idx + 1'b1;

`ifdef PLOT_ARB_CLIP_EN
    assign w_clip = w_oob;
`else
    // Range check stays elaborated but never suppresses a write.
    assign w_clip = w_oob & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_owner <= '0;
            r_burst <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_plot  <= 1'b0;
        end else begin
            r_plot <= w_any & ~w_clip;
            if (w_any && !w_clip) begin
                r_x     <= w_sel_x;
                r_y     <= w_sel_y;
                r_color <= w_sel_c;
            end
            case (r_state)
                ARB: begin
                    if (w_any) begin
                        r_ptr   <= w_ptr_next;
                        r_owner <= w_rr_idx;
                        if (lock[w_rr_idx]) begin
                            r_state <= LOCKED;
                            r_burst <= BW'(1);
                        end
                    end
                end
                LOCKED: begin
                    // Burst counter runs even when the owner idles.
                    r_burst <= r_burst + 1'b1;
                    if (!lock[r_owner] || w_last) begin
                        r_state <= ARB;
                        r_burst <= '0;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign gnt        = w_gnt;
    assign x          = r_x;
    assign y          = r_y;
    assign color_draw = r_color;
    assign plot       = r_plot;
    assign locked     = (r_state == LOCKED);
    assign owner      = r_owner;

endmodule : plot_arbiter
`default_nettype wire

// File: tb/tb_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_plot_arbiter
// Brief  : Self-checking bench for plot_arbiter (vector table + corner cases).
// Rev    : 1.0  initial release
// ============================================================================
module tb_plot_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [7:0]  px [3];
    logic [6:0]  py [3];
    logic [2:0]  pc [3];
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_color;
    logic [2:0]  gnt;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color_draw;
    logic        plot;
    logic        locked;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    assign req_x     = {px[2], px[1], px[0]};
    assign req_y     = {py[2], py[1], py[0]};
    assign req_color = {pc[2], pc[1], pc[0]};

    plot_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_color  (req_color),
        .gnt        (gnt),
        .x          (x),
        .y          (y),
        .color_draw (color_draw),
        .plot       (plot),
        .locked     (locked),
        .owner      (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // src: requester whose payload should sit on x/y/color; 3 = reset zeros
    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic [2:0] gnt;
        logic       plot;
        int         src;
        logic       locked;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [2:0] r, input logic [2:0] l, input logic [2:0] g,
                                input logic p, input int s, input logic lk);
        vecs.push_back('{r, l, g, p, s, lk});
    endfunction

    task automatic chk_payload(input string name, input int s);
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        ex = (s == 3) ? 8'd0 : px[s];
        ey = (s == 3) ? 7'd0 : py[s];
        ec = (s == 3) ? 3'd0 : pc[s];
        chk({name, ".x"}, 32'(x), 32'(ex));
        chk({name, ".y"}, 32'(y), 32'(ey));
        chk({name, ".c"}, 32'(color_draw), 32'(ec));
    endtask

    // Called at posedge+1: drive, check gnt, step one edge, check outputs.
    task automatic run_vec(input int i, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", i);
        req  = v.req;
        lock = v.lock;
        #1;
        chk({nm, ".gnt"}, 32'(gnt), 32'(v.gnt));
        @(posedge clk);
        #1;
        chk({nm, ".plot"}, 32'(plot), 32'(v.plot));
        chk({nm, ".locked"}, 32'(locked), 32'(v.locked));
        chk_payload(nm, v.src);
    endtask

    initial begin
        logic [7:0] last_x;

        px[0] = 8'd10;  py[0] = 7'd20;  pc[0] = 3'd1;
        px[1] = 8'd30;  py[1] = 7'd40;  pc[1] = 3'd2;
        px[2] = 8'd50;  py[2] = 7'd60;  pc[2] = 3'd3;
        reset = 1'b1;
        req   = 3'b000;
        lock  = 3'b000;

        // Fairness: 0,1,2,0 with no gaps
        add(3'b111, 3'b000, 3'b001, 1'b1, 0, 1'b0);
        add(3'b111, 3'b000, 3'b010, 1'b1, 1, 1'b0);
        add(3'b111, 3'b000, 3'b100, 1'b1, 2, 1'b0);
        add(3'b111, 3'b000, 3'b001, 1'b1, 0, 1'b0);
        // Requester 1 locks: 16 beats then forced release, then 2, then 0
        for (int k = 1; k <= 16; k++)
            add(3'b111, 3'b010, 3'b010, 1'b1, 1, (k < 16));
        add(3'b111, 3'b010, 3'b100, 1'b1, 2, 1'b0);
        add(3'b111, 3'b010, 3'b001, 1'b1, 0, 1'b0);
        // Requester 0 burst, lock dropped on 5th beat, then requester 1
        add(3'b001, 3'b001, 3'b001, 1'b1, 0, 1'b1);
        for (int k = 0; k < 3; k++)
            add(3'b111, 3'b001, 3'b001, 1'b1, 0, 1'b1);
        add(3'b111, 3'b000, 3'b001, 1'b1, 0, 1'b0);
        add(3'b111, 3'b000, 3'b010, 1'b1, 1, 1'b0);
        // Requester 2 locks then idles: nobody else may write
        add(3'b111, 3'b100, 3'b100, 1'b1, 2, 1'b1);
        for (int k = 0; k < 3; k++)
            add(3'b011, 3'b100, 3'b000, 1'b0, 2, 1'b1);
        add(3'b111, 3'b000, 3'b100, 1'b1, 2, 1'b0);
        add(3'b111, 3'b000, 3'b001, 1'b1, 0, 1'b0);
        // All idle: no grant, pointer unchanged
        add(3'b000, 3'b000, 3'b000, 1'b0, 0, 1'b0);
        add(3'b111, 3'b000, 3'b010, 1'b1, 1, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        req = 3'b111;
        #1;
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.plot", 32'(plot), 32'd0);
        chk("rst.locked", 32'(locked), 32'd0);
        chk("rst.owner", 32'(owner), 32'd0);
        chk_payload("rst", 3);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset in the middle of a burst on requester 1
        run_vec(100, '{3'b010, 3'b010, 3'b010, 1'b1, 1, 1'b1});
        for (int k = 0; k < 3; k++)
            run_vec(101 + k, '{3'b111, 3'b010, 3'b010, 1'b1, 1, 1'b1});
        reset = 1'b1;
        #1;
        chk("midrst.gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst.plot", 32'(plot), 32'd0);
        chk("midrst.locked", 32'(locked), 32'd0);
        chk("midrst.owner", 32'(owner), 32'd0);
        chk_payload("midrst", 3);
        reset = 1'b0;
        run_vec(104, '{3'b111, 3'b000, 3'b001, 1'b1, 0, 1'b0});
        chk("postrst.owner", 32'(owner), 32'd0);

        // Screen-edge coordinates on requester 2 (pointer now at 1)
        px[2] = 8'd159; py[2] = 7'd119;
        run_vec(105, '{3'b100, 3'b000, 3'b100, 1'b1, 2, 1'b0});
        chk("edge.owner", 32'(owner), 32'd2);
        last_x = 8'd159;

        px[2] = 8'd165; py[2] = 7'd10;
        req = 3'b100;
        #1;
        chk("clipx.gnt", 32'(gnt), 32'b100);
        @(posedge clk);
        #1;
`ifdef PLOT_ARB_CLIP_EN
        chk("clipx.plot", 32'(plot), 32'd0);
        chk("clipx.x", 32'(x), 32'(last_x));
        chk("clipx.y", 32'(y), 32'd119);
`else
        chk("clipx.plot", 32'(plot), 32'd1);
        chk("clipx.x", 32'(x), 32'd165);
        chk("clipx.y", 32'(y), 32'd10);
        last_x = 8'd165;
`endif

        px[2] = 8'd12; py[2] = 7'd120;
        #1;
        chk("clipy.gnt", 32'(gnt), 32'b100);
        @(posedge clk);
        #1;
`ifdef PLOT_ARB_CLIP_EN
        chk("clipy.plot", 32'(plot), 32'd0);
        chk("clipy.x", 32'(x), 32'(last_x));
`else
        chk("clipy.plot", 32'(plot), 32'd1);
        chk("clipy.x", 32'(x), 32'd12);
        chk("clipy.y", 32'(y), 32'd120);
`endif

        req = 3'b000;
        #1;
        chk("idle.gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("idle.plot", 32'(plot), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_plot_arbiter
`default_nettype wire
